bus_mapper: RTL
===============

Name: bus_mapper

Overview:
- Parametrised, registered successor to the combinational pCPU address mapper.
- Decodes a CPU memory request against NSLV base/mask regions and forwards it to one slave.
- Waits for the slave's ready, then returns read data to the CPU with a single-cycle ready response.
- Adds a per-transaction timeout watchdog, unmapped-address fault detection, a sticky fault interrupt and a fault-address capture register.

Parameters:
- NSLV, 4, number of slave ports (1..8).
- BASE, {32'hf0000000,32'h90000000,32'h20000000,32'h10000000}, NSLV x 32 region base addresses; slave i uses bits [32i+31:32i].
- MASK, {4{32'hf0000000}}, NSLV x 32 region masks; slave i matches when (a & MASK_i) == BASE_i.
- TIMEOUT, 255, maximum number of BUSY cycles before abort (1..2^TW-1).
- TW, 8, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a  in  32  CPU address.
- d  in  32  CPU write data.
- we  in  1  CPU write request (level).
- rd  in  1  CPU read request (level).
- spo  out  32  read data returned to the CPU.
- ready  out  1  CPU handshake.
- irq  out  1  sticky bus-fault interrupt.
- irq_clr  in  1  pulse; clears irq.
- fault_addr  out  32  address of the most recent fault.
- s_a  out  32  latched address, common to all slaves.
- s_d  out  32  latched write data, common to all slaves.
- s_we  out  NSLV  per-slave write strobe.
- s_rd  out  NSLV  per-slave read strobe.
- s_spo  in  NSLV x 32  per-slave read data; slave i on bits [32i+31:32i].
- s_ready  in  NSLV  per-slave ready.

Behaviour:
- Reset values: state=IDLE, spo=0, irq=0, fault_addr=0, s_a=0, s_d=0, s_we=0, s_rd=0, counter=0.
- An asserted rst_n low drops all strobes immediately, even mid-transaction.
- FSM states are IDLE, BUSY and RESP.
- ready = (IDLE & ~(rd|we)) | RESP. It is purely a function of state and the request inputs.
- IDLE:
  - On rd|we, latch a into s_a, d into s_d, and op=we (we has priority; if both are high the access is a write).
  - Decode sel as the lowest-index slave i with (a & MASK_i) == BASE_i.
  - Match: go to BUSY and clear the counter.
  - No match: go to RESP with fault=1 and spo=32'h0.
- BUSY:
  - Drive s_we[sel]=op or s_rd[sel]=~op; all other strobe bits are 0.
  - Increment the counter each cycle.
  - If s_ready[sel]=1: register spo <= s_spo[sel] (spo=0 for writes is not required; spo always takes s_spo[sel]), then go to RESP.
  - Else if counter == TIMEOUT-1: drop the strobes, set spo=32'h0 and fault=1, then go to RESP.
  - Slave ready is accepted on the same cycle the strobe is first driven, so the minimum BUSY duration is 1 cycle.
- RESP:
  - ready=1 for exactly one cycle and spo is valid; strobes are 0.
  - Go to IDLE unconditionally.
  - The CPU must deassert rd/we in the cycle after seeing ready; a request still present in IDLE starts a new transaction.
- Latency:
  - Mapped access: 1 (IDLE) + N (BUSY, N ≥ 1 slave-ready cycles) + 1 (RESP).
  - Unmapped access: 2 cycles.
  - Timeout: TIMEOUT+2 cycles.
- Fault handling:
  - On entering RESP with fault=1, set irq <= 1 and fault_addr <= s_a.
  - If a fault and irq_clr occur in the same cycle, the fault wins and irq stays 1.
  - irq_clr with no fault clears irq. fault_addr is never cleared except by reset.
- s_a and s_d hold their latched value until the next request is accepted in IDLE.
- s_ready of non-selected slaves is ignored, and s_ready is ignored outside BUSY.
- Overlapping regions resolve to the lowest index.
- Counter wrap is impossible because the exit happens at TIMEOUT-1.

Test Plan:
- Read 0x10000010, slave0 s_spo=32'h12345678, s_ready high immediately -> s_rd[0] high 1 cycle, ready in RESP 3 cycles after request, spo=32'h12345678, irq=0.
- Write 0x20000004 d=32'hcafef00d, slave1 s_ready delayed 5 cycles -> s_we[1] high exactly 5 cycles, s_d=32'hcafef00d, ready on cycle 7, no other strobe bit set.
- Read 0x50000000 (unmapped) -> no strobe, ready after 2 cycles, spo=0, irq=1, fault_addr=32'h50000000; irq_clr pulse -> irq=0.
- Read 0xf0000000 with slave3 s_ready stuck 0, TIMEOUT=255 -> s_rd[3] high 255 cycles then drops, ready, spo=0, irq=1, fault_addr=32'hf0000000.
- Fault coinciding with an irq_clr pulse -> irq remains 1; we and rd both high on a 0x9xxxxxxx address -> s_we[2] only.
- rst_n asserted low during BUSY -> s_we/s_rd drop asynchronously, irq=0, fault_addr=0; after release, a fresh read completes normally.

Source files
------------

// File: rtl/bus_mapper.sv
// Registered CPU-to-slave bus mapper: base/mask region decode, slave handshake,
// per-transaction timeout watchdog, and a sticky fault interrupt with address capture.
module bus_mapper #(
    parameter int                 NSLV    = 4,
    parameter logic [32*NSLV-1:0] BASE    = {32'hf0000000, 32'h90000000, 32'h20000000, 32'h10000000},
    parameter logic [32*NSLV-1:0] MASK    = {4{32'hf0000000}},
    parameter int                 TIMEOUT = 255,
    parameter int                 TW      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          a,
    input  logic [31:0]          d,
    input  logic                 we,
    input  logic                 rd,
    output logic [31:0]          spo,
    output logic                 ready,
    output logic                 irq,
    input  logic                 irq_clr,
    output logic [31:0]          fault_addr,
    output logic [31:0]          s_a,
    output logic [31:0]          s_d,
    output logic [NSLV-1:0]      s_we,
    output logic [NSLV-1:0]      s_rd,
    input  logic [32*NSLV-1:0]   s_spo,
    input  logic [NSLV-1:0]      s_ready
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_sel;
    logic            r_op;
    logic [TW-1:0]   r_cnt;
    logic [31:0]     r_spo;
    logic [31:0]     r_fault_addr;
    logic [31:0]     r_s_a;
    logic [31:0]     r_s_d;
    logic            r_irq;

    logic            w_req;
    logic            w_hit;
    logic [SW-1:0]   w_sel;
    logic            w_rdy_sel;
    logic [31:0]     w_spo_sel;
    logic            w_timeout;
    logic            w_fault;

    assign w_req     = rd | we;
    assign w_timeout = (r_cnt == CNT_LAST);

    // Scan from the top down so the lowest matching index is the one left in w_sel.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int unsigned i = NSLV; i > 0; i--) begin
            if ((a & MASK[32*(i-1) +: 32]) == BASE[32*(i-1) +: 32]) begin
                w_hit = 1'b1;
                w_sel = SW'(i - 1);
            end
        end
    end

    always_comb begin
        w_rdy_sel = 1'b0;
        w_spo_sel = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (r_sel == SW'(i)) begin
                w_rdy_sel = s_ready[i];
                w_spo_sel = s_spo[32*i +: 32];
            end
        end
    end

    assign w_fault = ((r_state == IDLE) && w_req && !w_hit) ||
                     ((r_state == BUSY) && !w_rdy_sel && w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = w_hit ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (w_rdy_sel || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        s_we  = '0;
        s_rd  = '0;
        case (r_state)
            IDLE: ready = ~w_req;
            RESP: ready = 1'b1;
            default: ready = 1'b0;
        endcase
        for (int unsigned i = 0; i < NSLV; i++) begin
            s_we[i] = (r_state == BUSY) &&  r_op && (r_sel == SW'(i));
            s_rd[i] = (r_state == BUSY) && !r_op && (r_sel == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_op         <= 1'b0;
            r_cnt        <= '0;
            r_spo        <= '0;
            r_s_a        <= '0;
            r_s_d        <= '0;
            r_irq        <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_s_a <= a;
                        r_s_d <= d;
                        r_op  <= we;
                        r_sel <= w_sel;
                        r_cnt <= '0;
                        if (!w_hit) begin
                            r_spo <= '0;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + TW'(1);
                    if (w_rdy_sel) begin
                        r_spo <= w_spo_sel;
                    end else if (w_timeout) begin
                        r_spo <= '0;
                    end
                end
                default: ;
            endcase

            // An unmapped fault is detected while s_a is being loaded, so capture a directly.
            if (w_fault) begin
                r_irq        <= 1'b1;
                r_fault_addr <= (r_state == IDLE) ? a : r_s_a;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign spo        = r_spo;
    assign irq        = r_irq;
    assign fault_addr = r_fault_addr;
    assign s_a        = r_s_a;
    assign s_d        = r_s_d;

endmodule
